// File: rtl/rtc_pkg.sv
// rtc_pkg: shared time-of-day limits, packed time type and range check
package rtc_pkg;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HOUR_MAX = 23;
  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
  } rtc_time_t;
  function automatic logic time_ok(rtc_time_t t);
    return t.hour <= 5'(HOUR_MAX) && t.minute <= 6'(MIN_MAX) && t.second <= 6'(SEC_MAX);
  endfunction
endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulo-MOD counter with increment, load and carry-out
module mod_counter #(
  parameter int W = 6,
  parameter int MOD = 60
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         carry
);
  assign carry = inc && q == W'(MOD - 1);
  always_ff @(posedge clk)
    q <= reset ? '0 : load ? load_val : carry ? '0 : inc ? q + W'(1) : q;
endmodule

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: prescaled hh:mm:ss + day keeper with pause, validated load and minute alarm
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int DAY_W = 16,
  parameter int PRE_W = $clog2(TICK_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             set_valid,
  output logic             set_ready,
  input  logic [4:0]       set_hour,
  input  logic [5:0]       set_min,
  input  logic [5:0]       set_sec,
  output logic             set_err,
  input  logic             alarm_en,
  input  logic [4:0]       alarm_hour,
  input  logic [5:0]       alarm_min,
  output logic [4:0]       hour,
  output logic [5:0]       minute,
  output logic [5:0]       second,
  output logic [DAY_W-1:0] day,
  output logic             sec_tick,
  output logic             min_tick,
  output logic             alarm
);
  logic [PRE_W-1:0] pre;
  rtc_time_t st;
  logic acc, ld, tick, inc, sc, mc, hc;
  logic [4:0] hn;
  logic [5:0] mn;
  assign st = '{hour: set_hour, minute: set_min, second: set_sec};
  assign acc = set_valid && set_ready;
  assign ld = acc && time_ok(st);
  assign tick = run && pre == PRE_W'(TICK_DIV - 1);
  assign inc = tick && !ld;
  // hour/minute as they will read after this edge, for the alarm compare
  assign mn = mc ? '0 : minute + 6'd1;
  assign hn = hc ? '0 : mc ? hour + 5'd1 : hour;
  mod_counter #(.W(6), .MOD(SEC_MAX + 1)) u_sec (
    .clk(clk), .reset(reset), .inc(inc), .load(ld), .load_val(st.second), .q(second), .carry(sc)
  );
  mod_counter #(.W(6), .MOD(MIN_MAX + 1)) u_min (
    .clk(clk), .reset(reset), .inc(sc), .load(ld), .load_val(st.minute), .q(minute), .carry(mc)
  );
  mod_counter #(.W(5), .MOD(HOUR_MAX + 1)) u_hour (
    .clk(clk), .reset(reset), .inc(mc), .load(ld), .load_val(st.hour), .q(hour), .carry(hc)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
      day <= '0;
      set_ready <= 1'b0;
      set_err <= 1'b0;
      sec_tick <= 1'b0;
      min_tick <= 1'b0;
      alarm <= 1'b0;
    end else begin
      pre <= (ld || tick) ? '0 : run ? pre + PRE_W'(1) : pre;
      day <= day + DAY_W'(hc);
      set_ready <= 1'b1;
      set_err <= acc && !time_ok(st);
      sec_tick <= inc;
      min_tick <= sc;
      alarm <= sc && alarm_en && hn == alarm_hour && mn == alarm_min;
    end
  end
endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper: directed self-checking bench, TICK_DIV=4, DAY_W=4
module tb_rtc_timekeeper;
  logic clk = 0, reset = 1, run = 0, set_valid = 0, alarm_en = 0;
  logic [4:0] set_hour = 0, alarm_hour = 0;
  logic [5:0] set_min = 0, set_sec = 0, alarm_min = 0;
  logic set_ready, set_err, sec_tick, min_tick, alarm;
  logic [4:0] hour;
  logic [5:0] minute, second;
  logic [3:0] day;
  int total = 0, bad = 0;

  rtc_timekeeper #(.TICK_DIV(4), .DAY_W(4)) dut (
    .clk(clk), .reset(reset), .run(run), .set_valid(set_valid), .set_ready(set_ready),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec), .set_err(set_err),
    .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .hour(hour), .minute(minute), .second(second), .day(day),
    .sec_tick(sec_tick), .min_tick(min_tick), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    set_hour = h; set_min = m; set_sec = s; set_valid = 1;
    step(1);
    set_valid = 0;
  endtask

  task automatic test_reset;
    reset = 1; run = 1;
    step(2);
    total++;
    if ({hour, minute, second, day} !== 21'd0) begin
      bad++; $display("FAIL reset_time got %0d:%0d:%0d day %0d want 0:0:0 day 0", hour, minute, second, day);
    end
    total++;
    if ({set_ready, set_err, sec_tick, min_tick, alarm} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got %b want 00000", {set_ready, set_err, sec_tick, min_tick, alarm});
    end
  endtask

  task automatic test_count;
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      total++;
      if (sec_tick !== (i % 4 == 3)) begin
        bad++; $display("FAIL count_tick cycle %0d got %b want %b", i, sec_tick, i % 4 == 3);
      end
      if (i == 0) begin
        total++;
        if (set_ready !== 1'b1) begin
          bad++; $display("FAIL set_ready got %b want 1", set_ready);
        end
      end
    end
    total++;
    if ({hour, minute, second} !== {5'd0, 6'd0, 6'd4}) begin
      bad++; $display("FAIL count_time got %0d:%0d:%0d want 0:0:4", hour, minute, second);
    end
  endtask

  task automatic test_rollover;
    do_load(23, 59, 58);
    total++;
    if ({hour, minute, second, sec_tick, set_err} !== {5'd23, 6'd59, 6'd58, 2'b00}) begin
      bad++; $display("FAIL load_time got %0d:%0d:%0d tick %b err %b want 23:59:58 tick 0 err 0", hour, minute, second, sec_tick, set_err);
    end
    step(4);
    total++;
    if (second !== 6'd59) begin
      bad++; $display("FAIL roll_pre got sec %0d want 59", second);
    end
    step(4);
    total++;
    if ({hour, minute, second, day} !== {5'd0, 6'd0, 6'd0, 4'd1}) begin
      bad++; $display("FAIL roll_time got %0d:%0d:%0d day %0d want 0:0:0 day 1", hour, minute, second, day);
    end
    total++;
    if ({sec_tick, min_tick, set_err} !== 3'b110) begin
      bad++; $display("FAIL roll_ticks got %b want 110", {sec_tick, min_tick, set_err});
    end
  endtask

  task automatic test_bad_load;
    do_load(24, 0, 0);
    total++;
    if ({set_err, hour, minute, second} !== {1'b1, 5'd0, 6'd0, 6'd0}) begin
      bad++; $display("FAIL bad_hour got err %b %0d:%0d:%0d want err 1 0:0:0", set_err, hour, minute, second);
    end
    step(1);
    total++;
    if (set_err !== 1'b0) begin
      bad++; $display("FAIL err_pulse got %b want 0", set_err);
    end
    step(2);
    total++;
    if ({sec_tick, second} !== {1'b1, 6'd1}) begin
      bad++; $display("FAIL bad_continue got tick %b sec %0d want tick 1 sec 1", sec_tick, second);
    end
    do_load(1, 2, 60);
    total++;
    if ({set_err, hour, minute, second} !== {1'b1, 5'd0, 6'd0, 6'd1}) begin
      bad++; $display("FAIL bad_sec got err %b %0d:%0d:%0d want err 1 0:0:1", set_err, hour, minute, second);
    end
  endtask

  task automatic test_alarm;
    int cnt;
    alarm_hour = 7; alarm_min = 30; alarm_en = 1;
    do_load(7, 29, 59);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (alarm) cnt++;
      if (i == 3) begin
        total++;
        if ({alarm, hour, minute, second} !== {1'b1, 5'd7, 6'd30, 6'd0}) begin
          bad++; $display("FAIL alarm_hit got alarm %b %0d:%0d:%0d want 1 7:30:0", alarm, hour, minute, second);
        end
      end
    end
    total++;
    if (cnt !== 1) begin
      bad++; $display("FAIL alarm_count got %0d want 1", cnt);
    end
    do_load(7, 30, 0);
    cnt = alarm ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (alarm) cnt++;
    end
    total++;
    if (cnt !== 0) begin
      bad++; $display("FAIL alarm_load got %0d pulses want 0", cnt);
    end
    alarm_en = 0;
  endtask

  task automatic test_pause;
    int moved;
    do_load(10, 20, 30);
    step(2);
    run = 0;
    moved = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (sec_tick || {hour, minute, second} !== {5'd10, 6'd20, 6'd30}) moved++;
    end
    total++;
    if (moved !== 0) begin
      bad++; $display("FAIL pause_hold got %0d changed cycles want 0", moved);
    end
    run = 1;
    step(1);
    total++;
    if (sec_tick !== 1'b0) begin
      bad++; $display("FAIL resume_early got tick %b want 0", sec_tick);
    end
    step(1);
    total++;
    if ({sec_tick, second} !== {1'b1, 6'd31}) begin
      bad++; $display("FAIL resume_tick got tick %b sec %0d want tick 1 sec 31", sec_tick, second);
    end
  endtask

  task automatic test_load_at_terminal;
    do_load(12, 0, 0);
    step(3);
    do_load(5, 6, 7);
    total++;
    if ({sec_tick, hour, minute, second} !== {1'b0, 5'd5, 6'd6, 6'd7}) begin
      bad++; $display("FAIL term_load got tick %b %0d:%0d:%0d want tick 0 5:6:7", sec_tick, hour, minute, second);
    end
    for (int i = 0; i < 4; i++) begin
      step(1);
      total++;
      if (sec_tick !== (i == 3)) begin
        bad++; $display("FAIL term_next cycle %0d got %b want %b", i, sec_tick, i == 3);
      end
    end
    total++;
    if (second !== 6'd8) begin
      bad++; $display("FAIL term_sec got %0d want 8", second);
    end
  endtask

  task automatic test_day_wrap;
    for (int i = 0; i < 14; i++) begin
      do_load(23, 59, 59);
      step(4);
    end
    total++;
    if (day !== 4'd15) begin
      bad++; $display("FAIL day_15 got %0d want 15", day);
    end
    do_load(23, 59, 59);
    step(4);
    total++;
    if ({day, hour, minute, second} !== 21'd0) begin
      bad++; $display("FAIL day_wrap got day %0d %0d:%0d:%0d want day 0 0:0:0", day, hour, minute, second);
    end
  endtask

  task automatic test_mid_reset;
    do_load(3, 4, 5);
    step(2);
    reset = 1;
    step(1);
    total++;
    if ({hour, minute, second, day, sec_tick, set_ready} !== 23'd0) begin
      bad++; $display("FAIL mid_reset got %0d:%0d:%0d day %0d tick %b rdy %b want all 0", hour, minute, second, day, sec_tick, set_ready);
    end
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      total++;
      if (sec_tick !== (i == 3)) begin
        bad++; $display("FAIL mid_reset_tick cycle %0d got %b want %b", i, sec_tick, i == 3);
      end
    end
  endtask

  initial begin
    test_reset;
    test_count;
    test_rollover;
    test_bad_load;
    test_alarm;
    test_pause;
    test_load_at_terminal;
    test_day_wrap;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rtc_timekeeper.md
# rtc_timekeeper

Parametrised time-of-day keeper for the parking controller: a programmable prescaler drives cascaded second/minute/hour counters plus a day counter, with run/pause, validated time load, and a single minute-resolution alarm. Entry/exit timestamping and fee logic read its outputs and tick strobes. It is the successor to the fixed-rate hour/minute timer: adds seconds, day count, presetting, pause and alarm.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per second, ≥ 2.
- `DAY_W`, default 16: day counter width.
- `PRE_W`, default $clog2(TICK_DIV): prescaler width.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `run`  in  1  counting enabled when high; prescaler holds when low.
- `set_valid`  in  1  load request.
- `set_ready`  out  1  load can be accepted.
- `set_hour`  in  5  load value, 0..23.
- `set_min`  in  6  load value, 0..59.
- `set_sec`  in  6  load value, 0..59.
- `set_err`  out  1  one-cycle pulse: load rejected, out of range.
- `alarm_en`  in  1  alarm armed.
- `alarm_hour`  in  5  alarm hour.
- `alarm_min`  in  6  alarm minute.
- `hour`  out  5  0..23.
- `minute`  out  6  0..59.
- `second`  out  6  0..59.
- `day`  out  DAY_W  days elapsed, wraps modulo 2^DAY_W.
- `sec_tick`  out  1  pulse in the cycle a new second value first appears.
- `min_tick`  out  1  pulse in the cycle a new minute value first appears.
- `alarm`  out  1  one-cycle pulse on alarm match.

## Operation
- Reset: prescaler, hour, minute, second, day = 0; `set_ready`, `set_err`, `sec_tick`, `min_tick`, `alarm` = 0.
- Prescaler counts 0..TICK_DIV-1 while `run`=1. On the edge where it is at TICK_DIV-1 it wraps to 0 and a second increment is issued.
- Cascade in the same edge:
  - second 59→0 carries to minute;
  - minute 59→0 carries to hour;
  - hour 23→0 carries to day (+1, modulo 2^DAY_W).
- Values never leave their ranges.
- `run`=0 freezes all counters and the prescaler phase. Resuming continues from the held phase.
- Load:
  - `set_ready`=1 in every cycle after reset is released.
  - A load is accepted on an edge where `set_valid && set_ready`.
  - In-range values load hour/minute/second and clear the prescaler to 0. `day` is untouched.
  - Any field out of range: nothing changes, and `set_err` pulses the next cycle.
  - A load suppresses any increment due in that cycle. No ticks are generated by a load.
- Priority: reset > accepted load > increment.
- Alarm:
  - Fires only on an increment edge that makes second=0 with the new hour/minute equal to `alarm_hour`/`alarm_min`, and `alarm_en`=1.
  - A load landing on the alarm time does not fire it.
  - An out-of-range alarm setting never fires.

## Timing
- All outputs are registered; no combinational input→output paths.
- Increment latency:
  - `second` changes one clk edge after the prescaler reaches TICK_DIV-1, i.e. every TICK_DIV cycles at steady `run`.
  - `sec_tick` is high in the first cycle the new value is visible.
  - `min_tick` and `alarm` are coincident with `sec_tick` when applicable.
- Load latency: new values are visible the cycle after acceptance. The first subsequent `sec_tick` arrives TICK_DIV cycles after acceptance (with `run`=1).
- Reset asserted mid-count: all state clears on that edge. The first `sec_tick` comes TICK_DIV cycles after reset deasserts (with `run`=1).
- Full rollover 23:59:59→00:00:00: `day`+1, with `sec_tick` and `min_tick` high in the same cycle.

## Structure
- Shared package `rtc_pkg`:
  - constants `SEC_MAX`=59, `MIN_MAX`=59, `HOUR_MAX`=23;
  - typedef `rtc_time_t` (packed hour/minute/second).
- Sub-module `mod_counter`, parametrised by width and modulus, with inc/load/carry-out; instantiated for second, minute and hour.
- Prescaler, day counter, load validation and alarm compare live in the top.

## Test plan
Bench uses `TICK_DIV`=4, `DAY_W`=4.
- Reset, then `run`=1 for 16 cycles → `second`=4; `sec_tick` pulses exactly every 4 cycles; the first pulse comes 4 cycles after reset release.
- Load 23:59:58, run 8 cycles → 00:00:00 with `day`=1; `sec_tick` and `min_tick` both high at the rollover; `set_err`=0.
- Load hour=24 (or sec=60) → `set_err` pulses once; time unchanged; counting continues.
- Alarm 07:30 with `alarm_en`=1:
  - Load 07:29:59 → `alarm` pulses once when 07:30:00 appears.
  - Load 07:30:00 directly → no pulse.
- `run`=0 at prescaler phase 2 for 10 cycles → no change. Resume → `sec_tick` occurs 2 cycles later.
- Load accepted in the same cycle as the prescaler terminal → loaded value is shown, with no increment and no `sec_tick`.
- `day` at 15 plus a day rollover → wraps to 0.
